// File: rtl/mac_result_reader_pkg.sv
// ---------------------------------------------------------------------------
// mac_result_reader_pkg
//   Shared definitions for the C-matrix result reader:
//   - reader_state_e : drain FSM states
//   - BUF_DEPTH      : depth of the output skid buffer
//   - BUF_CNT_W      : width of the buffer occupancy count
//   - result_width() : C element width derived from operand width and K,
//                      shared with the MAC stages so all agree on it.
// ---------------------------------------------------------------------------
package mac_result_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // A K-term sum of products of two init_w-bit operands needs
  // 2*init_w bits per product plus clog2(K) bits of carry growth.
  function automatic int unsigned result_width(input int unsigned init_w,
                                               input int unsigned k);
    return 2 * init_w + $clog2(k);
  endfunction

endpackage

// File: rtl/mac_result_reader_skid_fifo.sv
// ---------------------------------------------------------------------------
// result_skid_fifo
//   Two-entry first-word-fall-through buffer between the synchronous-read
//   C memory and the valid/ready output. Simultaneous push and pop keeps
//   the count unchanged and preserves order. The caller guarantees no push
//   into a full buffer without a pop and no pop from an empty buffer.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to write
//   pop_i        : retire the head entry
//   pop_data_o   : head entry (zero while empty)
//   count_o      : number of valid entries (0..2)
//   empty_o      : no valid entries
//   full_o       : both entries valid
// ---------------------------------------------------------------------------
module result_skid_fifo
  import mac_result_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     pop_data_o,
  output logic [BUF_CNT_W-1:0] count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  // With exactly two entries a single bit addresses the storage.
  logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [BUF_CNT_W-1:0] count_q;
  logic [BUF_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // NOTE: the data storage has no reset; pointers and count define what is
  // valid, and the head is masked to zero while empty so nothing stale leaks.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == BUF_CNT_W'(BUF_DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mac_result_reader.sv
// ---------------------------------------------------------------------------
// mac_result_reader
//   Drains the M x N result matrix C from its synchronous-read memory in
//   row-major order after the MAC stage signals done, and streams it over
//   valid/ready with out_last on C[M-1][N-1]. Reads are throttled so the
//   2-entry output buffer never overflows while still sustaining one
//   element per cycle when out_ready stays high.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse, honoured only when idle
//   matrix_c_re       : C memory read enable
//   row_addr_c/col_addr_c : C read address (held while not reading)
//   data_in_c         : C read data, valid one cycle after matrix_c_re
//   out_data/out_valid/out_ready/out_last : output stream
//   busy              : drain in progress
//   drain_done        : one-cycle pulse after the last handshake
// ---------------------------------------------------------------------------
module mac_result_reader
  import mac_result_reader_pkg::*;
#(
  parameter int unsigned M                        = 4,
  parameter int unsigned N                        = 4,
  parameter int unsigned K                        = 4,
  parameter int unsigned DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int unsigned DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                matrix_c_re,
  output logic [$clog2(M)-1:0]                row_addr_c,
  output logic [$clog2(N)-1:0]                col_addr_c,
  input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                drain_done
);

  localparam int unsigned RW = $clog2(M);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned DW = DATA_WIDTH_RESULT_MATRIX;
  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

  reader_state_e        state_q;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic                 in_flight_q;
  logic                 in_flight_last_q;
  logic                 busy_q;
  logic                 drain_done_q;

  logic                 issue;
  logic                 pop;
  logic                 at_last_addr;
  logic                 drained;
  logic [BUF_CNT_W-1:0] fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DW:0]          fifo_head;

  assign pop          = out_valid && out_ready;
  assign at_last_addr = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Occupancy the buffer would reach if another read is issued now: what is
  // stored, plus the read still in flight, minus the entry leaving this edge.
  // Gated by reset so an aborted drain issues no further reads.
  assign issue = !reset && (state_q == ST_READ) &&
                 ((3'(fifo_count) + 3'(in_flight_q)) < (3'(BUF_DEPTH) + 3'(pop)));

  // The buffer empties at this edge: nothing in flight and at most the head
  // entry left, which is being accepted now. Looking one edge ahead lets
  // drain_done follow the final handshake by exactly one cycle.
  assign drained = !in_flight_q &&
                   ((fifo_count == '0) || ((fifo_count == BUF_CNT_W'(1)) && pop));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      row_q            <= '0;
      col_q            <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      busy_q           <= 1'b0;
      drain_done_q     <= 1'b0;
    end else begin
      in_flight_q      <= issue;
      in_flight_last_q <= issue && at_last_addr;
      drain_done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_READ;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (at_last_addr) begin
              // Counters stay on the final address so the port holds it.
              state_q <= ST_DRAIN;
            end else if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          // A start landing on the drain_done cycle is deliberately dropped.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  result_skid_fifo #(
    .WIDTH(DW + 1)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_flight_q),
    .push_data_i ({in_flight_last_q, data_in_c}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign matrix_c_re = issue;
  assign row_addr_c  = row_q;
  assign col_addr_c  = col_q;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_head[DW-1:0];
  assign out_last    = fifo_head[DW];
  assign busy        = busy_q;
  assign drain_done  = drain_done_q;

  // Full is implied by the issue rule; kept on the sub-module for reuse.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_mac_result_reader.sv
module tb_mac_result_reader;
  import mac_result_reader_pkg::*;

  localparam int DW = result_width(32, 4);

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start_drv;
  logic out_ready;
  logic sel;

  // 4x4 instance
  logic          re4, valid4, last4, busy4, done4;
  logic [1:0]    row4, col4;
  logic [DW-1:0] rdata4, data4;
  // 2x3 instance
  logic          re23, valid23, last23, busy23, done23;
  logic [0:0]    row23;
  logic [1:0]    col23;
  logic [DW-1:0] rdata23, data23;

  logic          s_re, s_valid, s_last, s_busy, s_done;
  logic [3:0]    s_row, s_col;
  logic [DW-1:0] s_data;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_result_reader #(.M(4), .N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start_drv && !sel),
    .matrix_c_re(re4), .row_addr_c(row4), .col_addr_c(col4),
    .data_in_c(rdata4), .out_data(data4), .out_valid(valid4),
    .out_ready(out_ready), .out_last(last4), .busy(busy4), .drain_done(done4)
  );

  mac_result_reader #(.M(2), .N(3)) dut23 (
    .clk(clk), .reset(reset), .start(start_drv && sel),
    .matrix_c_re(re23), .row_addr_c(row23), .col_addr_c(col23),
    .data_in_c(rdata23), .out_data(data23), .out_valid(valid23),
    .out_ready(out_ready), .out_last(last23), .busy(busy23), .drain_done(done23)
  );

  // Synchronous-read C memories holding C[r][c] = 16r + c.
  always @(posedge clk) begin
    if (re4)  rdata4  <= DW'(16 * row4 + col4);
    if (re23) rdata23 <= DW'(16 * row23 + col23);
  end

  assign s_re    = sel ? re23    : re4;
  assign s_valid = sel ? valid23 : valid4;
  assign s_last  = sel ? last23  : last4;
  assign s_busy  = sel ? busy23  : busy4;
  assign s_done  = sel ? done23  : done4;
  assign s_data  = sel ? data23  : data4;
  assign s_row   = sel ? 4'(row23) : 4'(row4);
  assign s_col   = sel ? 4'(col23) : 4'(col4);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: out_ready always 1; mode 1: ready 1,0,1,0...; mode 2: ready 0
  // for cycles 1..10 then 1. Extra start pulses land in cycles xa/xb.
  // abort>0 returns at that cycle (before driving it) without final checks.
  task automatic run_drain(input bit sel23, input int mode, input int xa, input int xb,
                           input int abort, input string tag);
    int total, ncols, rd_idx, popped, elems, done_pulses, done_cyc, first_valid, reads_pre;
    bit last_seen, prev_stall, pop_now, prev_last;
    logic [DW-1:0] prev_data;
    exp_t e;
    total = sel23 ? 6 : 16;
    ncols = sel23 ? 3 : 4;
    rd_idx = 0; popped = 0; elems = 0; done_pulses = 0; done_cyc = -1;
    first_valid = -1; reads_pre = 0; last_seen = 0; prev_stall = 0;
    prev_last = 0; prev_data = '0;
    sel = sel23;
    exp_q.delete();
    for (int i = 0; i < total; i++) begin
      e.data = DW'(16 * (i / ncols) + i % ncols);
      e.last = (i == total - 1);
      exp_q.push_back(e);
    end
    start_drv = 1'b1;  // sampled at edge 0
    out_ready = (mode != 2);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (abort > 0 && cyc == abort) return;
      start_drv = (cyc == xa) || (cyc == xb);
      case (mode)
        1:       out_ready = (cyc % 2 == 1);
        2:       out_ready = (cyc > 10);
        default: out_ready = 1'b1;
      endcase
      #1;
      pop_now = s_valid && out_ready;
      if (s_re) begin
        check({tag, "_issue_rule"}, 128'((rd_idx - popped - int'(pop_now)) < 2), 128'(1));
        if (rd_idx < total)
          check({tag, "_addr"}, 128'({s_row, s_col}),
                128'({4'(rd_idx / ncols), 4'(rd_idx % ncols)}));
        else
          check({tag, "_extra_read"}, 128'(rd_idx), 128'(total - 1));
        rd_idx++;
        if (cyc <= 10) reads_pre++;
      end
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 128'(s_valid), 128'(1));
        check({tag, "_hold_data"}, 128'(s_data), 128'(prev_data));
        check({tag, "_hold_last"}, 128'(s_last), 128'(prev_last));
      end
      if (s_valid && first_valid < 0) first_valid = cyc;
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_elem"}, 128'(elems + 1), 128'(total));
        end else begin
          e = exp_q.pop_front();
          check({tag, "_data"}, 128'(s_data), 128'(e.data));
          check({tag, "_last"}, 128'(s_last), 128'(e.last));
        end
        if (s_last) last_seen = 1;
        elems++;
        popped++;
      end
      if (mode == 0 && abort == 0)
        check({tag, "_busy"}, 128'(s_busy), 128'(cyc <= total + 2));
      if (s_done) begin
        done_pulses++;
        done_cyc = cyc;
        check({tag, "_done_after_last"}, 128'(last_seen), 128'(1));
      end
      prev_stall = s_valid && !out_ready;
      prev_data  = s_data;
      prev_last  = s_last;
      if (done_pulses > 0 && cyc >= done_cyc + 6) break;
    end
    start_drv = 1'b0;
    check({tag, "_elems"}, 128'(elems), 128'(total));
    check({tag, "_done_pulses"}, 128'(done_pulses), 128'(1));
    check({tag, "_queue_left"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_first_valid"}, 128'(first_valid), 128'(3));
    if (mode == 0) check({tag, "_done_cycle"}, 128'(done_cyc), 128'(total + 3));
    if (mode == 2) check({tag, "_reads_pre_stall"}, 128'(reads_pre), 128'(2));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_re"},    128'(re4),    128'(0));
    check({tag, "_valid"}, 128'(valid4), 128'(0));
    check({tag, "_data"},  128'(data4),  128'(0));
    check({tag, "_last"},  128'(last4),  128'(0));
    check({tag, "_busy"},  128'(busy4),  128'(0));
    check({tag, "_done"},  128'(done4),  128'(0));
    check({tag, "_addr"},  128'({row4, col4}), 128'(0));
  endtask

  initial begin
    reset = 1'b1; start_drv = 1'b0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    run_drain(1'b0, 0, 0, 0, 0, "full_rate");
    run_drain(1'b0, 1, 0, 0, 0, "toggle");
    run_drain(1'b0, 2, 0, 0, 0, "stall");
    run_drain(1'b0, 0, 5, 19, 0, "restart_ign");

    run_drain(1'b0, 0, 0, 0, 8, "abort");
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    #1;
    check_idle_outputs("mid_reset2");
    reset = 1'b0;
    @(negedge clk);
    run_drain(1'b0, 0, 0, 0, 0, "after_reset");

    run_drain(1'b1, 0, 0, 0, 0, "m2n3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
